// File: rtl/axis_sample_discriminator.sv
// -----------------------------------------------------------------------------
// axis_sample_discriminator
//
// Per-channel hysteresis gate for parallel-sample AXI-Stream beats. A channel
// enters the "high" (event) state when any sample of a beat is strictly above
// threshold_high. It leaves that state when every sample is strictly below
// threshold_low. Only beats evaluated in the high state are forwarded. Each
// low-to-high entry also emits a timestamp {timer, sample_index}.
//
// Optional feature (compile-time macro):
//   SAMPLE_DISCRIMINATOR_RESET_TIMER_EN
//     When defined, reset_state also clears the per-channel beat timer.
//     When undefined (default), only i_reset clears the timer.
//
// Ports (AXI-Stream interfaces flattened; channel i is slice i):
//   clk                     sole clock
//   i_reset                 synchronous active-high reset
//   i_data_in_data/valid    input beats; o_data_in_ready is held 1
//   o_data_out_data/valid   gated beats, 1-cycle latency; no backpressure
//   o_timestamps_out_data   {timer, sample_index} per channel
//   o_timestamps_out_valid  one pulse per event start, aligned with the
//                           first forwarded beat of the event
//   i_config_in_data/valid  {threshold_high, threshold_low} per channel;
//                           o_config_in_ready is held 1
//   i_reset_state           pulse: clears is_high and sample_index
//
// The output streams have no ready inputs because the downstream consumer
// must always accept them.
// -----------------------------------------------------------------------------
module axis_sample_discriminator #(
  parameter int SAMPLE_WIDTH       = 16,
  parameter int PARALLEL_SAMPLES   = 4,
  parameter int N_CHANNELS         = 2,
  parameter int SAMPLE_INDEX_WIDTH = 14,
  parameter int CLOCK_WIDTH        = 50
) (
  input  logic                                                    clk,
  input  logic                                                    i_reset,
  input  logic [N_CHANNELS*SAMPLE_WIDTH*PARALLEL_SAMPLES-1:0]     i_data_in_data,
  input  logic [N_CHANNELS-1:0]                                   i_data_in_valid,
  output logic [N_CHANNELS-1:0]                                   o_data_in_ready,
  output logic [N_CHANNELS*SAMPLE_WIDTH*PARALLEL_SAMPLES-1:0]     o_data_out_data,
  output logic [N_CHANNELS-1:0]                                   o_data_out_valid,
  output logic [N_CHANNELS*(CLOCK_WIDTH+SAMPLE_INDEX_WIDTH)-1:0]  o_timestamps_out_data,
  output logic [N_CHANNELS-1:0]                                   o_timestamps_out_valid,
  input  logic [N_CHANNELS*2*SAMPLE_WIDTH-1:0]                    i_config_in_data,
  input  logic                                                    i_config_in_valid,
  output logic                                                    o_config_in_ready,
  input  logic                                                    i_reset_state
);

  localparam int BEAT_W = SAMPLE_WIDTH * PARALLEL_SAMPLES;
  localparam int TS_W   = CLOCK_WIDTH + SAMPLE_INDEX_WIDTH;

  typedef enum logic {
    ST_LOW  = 1'b0,
    ST_HIGH = 1'b1
  } state_t;

  assign o_data_in_ready   = '1;
  assign o_config_in_ready = 1'b1;

  for (genvar ch = 0; ch < N_CHANNELS; ch++) begin : g_ch
    state_t                          r_state;
    state_t                          w_state_cur;
    state_t                          w_state_next;
    logic signed [SAMPLE_WIDTH-1:0]  r_thr_high;
    logic signed [SAMPLE_WIDTH-1:0]  r_thr_low;
    logic [CLOCK_WIDTH-1:0]          r_timer;
    logic [CLOCK_WIDTH-1:0]          w_timer_cur;
    logic [CLOCK_WIDTH-1:0]          w_timer_next;
    logic [SAMPLE_INDEX_WIDTH-1:0]   r_index;
    logic [SAMPLE_INDEX_WIDTH-1:0]   w_index_cur;
    logic [SAMPLE_INDEX_WIDTH-1:0]   w_index_next;
    logic [BEAT_W-1:0]               r_dout_data;
    logic                            r_dout_valid;
    logic [TS_W-1:0]                 r_ts_data;
    logic                            r_ts_valid;
    logic [BEAT_W-1:0]               w_beat;
    logic                            w_valid;
    logic                            w_any_above;
    logic                            w_all_below;
    logic                            w_trigger;
    logic                            w_forward;

    assign w_beat  = i_data_in_data[ch*BEAT_W +: BEAT_W];
    assign w_valid = i_data_in_valid[ch];

    // reset_state acts on the beat of the same cycle: the beat sees a fresh
    // low state and a zero index, so "current" values are muxed here.
    always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      w_state_cur = i_reset_state ? ST_LOW : r_state;
      w_index_cur = i_reset_state ? '0 : r_index;
`ifdef SAMPLE_DISCRIMINATOR_RESET_TIMER_EN
      w_timer_cur = i_reset_state ? '0 : r_timer;
`else
      w_timer_cur = r_timer;
`endif
      w_any_above  = 1'b0;
      w_all_below  = 1'b1;
      w_state_next = w_state_cur;
      w_trigger    = 1'b0;

      for (int j = 0; j < PARALLEL_SAMPLES; j++) begin
        if ($signed(w_beat[j*SAMPLE_WIDTH +: SAMPLE_WIDTH]) > r_thr_high) begin
          w_any_above = 1'b1;
        end
        if (!($signed(w_beat[j*SAMPLE_WIDTH +: SAMPLE_WIDTH]) < r_thr_low)) begin
          w_all_below = 1'b0;
        end
      end

      // Entering high takes priority over leaving it, so a beat that is
      // both above high and below low (mis-ordered thresholds) triggers.
      if (w_valid) begin
        if (w_any_above) begin
          w_trigger    = (w_state_cur == ST_LOW);
          w_state_next = ST_HIGH;
        end else if (w_all_below) begin
          w_state_next = ST_LOW;
        end
      end

      w_forward    = w_valid && (w_state_next == ST_HIGH);
      w_index_next = w_forward ? w_index_cur + 1'b1 : w_index_cur;
      w_timer_next = w_valid   ? w_timer_cur + 1'b1 : w_timer_cur;
    end

    always_ff @(posedge clk) begin
      if (i_reset) begin
        r_state      <= ST_LOW;
        r_thr_high   <= '0;
        r_thr_low    <= '0;
        r_timer      <= '0;
        r_index      <= '0;
        r_dout_data  <= '0;
        r_dout_valid <= 1'b0;
        r_ts_data    <= '0;
        r_ts_valid   <= 1'b0;
      end else begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        r_state      <= w_state_next;
        r_timer      <= w_timer_next;
        r_index      <= w_index_next;
        r_dout_valid <= w_forward;
        r_ts_valid   <= w_trigger;
        // New thresholds take effect from the next beat; this cycle's beat
        // was already compared against the registered (old) values.
        if (i_config_in_valid) begin
          r_thr_high <= i_config_in_data[2*SAMPLE_WIDTH*ch + SAMPLE_WIDTH +: SAMPLE_WIDTH];
          r_thr_low  <= i_config_in_data[2*SAMPLE_WIDTH*ch +: SAMPLE_WIDTH];
        end
        if (w_forward) begin
          r_dout_data <= w_beat;
        end
        if (w_trigger) begin
          r_ts_data <= {w_timer_cur, w_index_cur};
        end
      end
    end

    assign o_data_out_data[ch*BEAT_W +: BEAT_W]     = r_dout_data;
    assign o_data_out_valid[ch]                     = r_dout_valid;
    assign o_timestamps_out_data[ch*TS_W +: TS_W]   = r_ts_data;
    assign o_timestamps_out_valid[ch]               = r_ts_valid;
  end

endmodule

// File: tb/tb_axis_sample_discriminator.sv
// -----------------------------------------------------------------------------
// tb_axis_sample_discriminator
//
// Directed testbench for axis_sample_discriminator with default parameters
// (16-bit samples, 4 per beat, 2 channels, 14-bit index, 50-bit timer).
// Expected values are hand-computed and written inline. Inputs are driven 1
// time unit after the rising edge. Outputs are checked 1 time unit after the
// following rising edge, once the registered response is visible.
// Honours SAMPLE_DISCRIMINATOR_RESET_TIMER_EN for the timer expectations.
// -----------------------------------------------------------------------------
module tb_axis_sample_discriminator;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] data_in;
  logic [1:0]   data_in_valid;
  logic [1:0]   data_in_ready;
  logic [127:0] data_out;
  logic [1:0]   data_out_valid;
  logic [127:0] ts_out;
  logic [1:0]   ts_valid;
  logic [63:0]  cfg_data;
  logic         cfg_valid;
  logic         cfg_ready;
  logic         reset_state;

  int n_vec = 0;
  int n_err = 0;
  int quiet_hits;

`ifdef SAMPLE_DISCRIMINATOR_RESET_TIMER_EN
  localparam logic [49:0] T0_RS = 50'd0;
  localparam logic [49:0] T1_RS = 50'd0;
  localparam logic [49:0] T0_AFTER = 50'd2;
  localparam logic [49:0] T0_QUIET = 50'd403;
  localparam logic [49:0] T1_QUIET = 50'd401;
`else
  localparam logic [49:0] T0_RS = 50'd17;
  localparam logic [49:0] T1_RS = 50'd4;
  localparam logic [49:0] T0_AFTER = 50'd19;
  localparam logic [49:0] T0_QUIET = 50'd420;
  localparam logic [49:0] T1_QUIET = 50'd405;
`endif

  always #5 clk = ~clk;

  axis_sample_discriminator dut (
    .clk                    (clk),
    .i_reset                (reset),
    .i_data_in_data         (data_in),
    .i_data_in_valid        (data_in_valid),
    .o_data_in_ready        (data_in_ready),
    .o_data_out_data        (data_out),
    .o_data_out_valid       (data_out_valid),
    .o_timestamps_out_data  (ts_out),
    .o_timestamps_out_valid (ts_valid),
    .i_config_in_data       (cfg_data),
    .i_config_in_valid      (cfg_valid),
    .o_config_in_ready      (cfg_ready),
    .i_reset_state          (reset_state)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic beat(input int ch, input logic [15:0] s0, input logic [15:0] s1,
                      input logic [15:0] s2, input logic [15:0] s3);
    data_in[ch*64 +: 64] = {s3, s2, s1, s0};
    data_in_valid[ch]    = 1'b1;
  endtask

  task automatic idle(input int ch);
    data_in[ch*64 +: 64] = '0;
    data_in_valid[ch]    = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset         = 1'b1;
    data_in       = '0;
    data_in_valid = '0;
    cfg_data      = '0;
    cfg_valid     = 1'b0;
    reset_state   = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_dout_valid", {62'd0, data_out_valid}, 64'd0);
    check("rst_ts_valid",   {62'd0, ts_valid},       64'd0);
    check("rst_dout_data0", data_out[63:0],          64'd0);
    check("rst_ts_data0",   ts_out[63:0],            64'd0);
    check("ready",          {61'd0, data_in_ready, cfg_ready}, 64'd7);
    reset = 1'b0;

    // Thresholds 0/0: zero beat dropped, first positive sample triggers {1,0}
    beat(0, 16'h0, 16'h0, 16'h0, 16'h0); tick();
    check("zero_dropped", {62'd0, data_out_valid}, 64'd0);
    beat(0, 16'h5, 16'h0, 16'h0, 16'h0); tick();
    check("trig1_valid", {60'd0, ts_valid, data_out_valid}, 64'h5);
    check("trig1_ts",    ts_out[63:0],   {50'd1, 14'd0});
    check("trig1_data",  data_out[63:0], 64'h0000_0000_0000_0005);
    beat(0, 16'h0, 16'h0, 16'h0, 16'h0); tick();
    check("hold_zero",   {60'd0, ts_valid, data_out_valid}, 64'h1);
    beat(0, 16'h100, 16'h0, 16'h0, 16'h0); tick();
    check("hold_100",    data_out[63:0], 64'h0000_0000_0000_0100);

    // Config write with a beat in the same cycle: that beat uses 0/0
    cfg_data  = {16'h0, 16'h0, 16'h0400, 16'h03c0};
    cfg_valid = 1'b1;
    beat(0, 16'h0, 16'h0, 16'h0, 16'h0); tick();
    cfg_valid = 1'b0;
    check("cfg_same_cycle", {62'd0, data_out_valid}, 64'h1);

    // Between thresholds (sample == low, not strictly below): kept
    beat(0, 16'h3c0, 16'h0, 16'h0, 16'h0); tick();
    check("between_kept", {62'd0, data_out_valid}, 64'h1);
    // All below low: leave event
    beat(0, 16'h3bf, 16'h10, 16'h0, 16'h0); tick();
    check("all_below", {62'd0, data_out_valid}, 64'h0);
    // Sample exactly == high: no trigger
    beat(0, 16'h400, 16'h3ff, 16'h0, 16'h0); tick();
    check("eq_high_no_trig", {60'd0, ts_valid, data_out_valid}, 64'h0);
    // high+1 triggers; ts {8,5}
    beat(0, 16'h401, 16'h0, 16'h0, 16'h0); tick();
    check("high1_valid", {60'd0, ts_valid, data_out_valid}, 64'h5);
    check("high1_ts",    ts_out[63:0], {50'd8, 14'd5});
    beat(0, 16'h3d0, 16'h3c5, 16'h3ff, 16'h3c0); tick();
    check("hyst_kept", data_out[63:0], 64'h03c0_03ff_03c5_03d0);
    // Signed compare: -1 is below 0x3c0
    beat(0, 16'hffff, 16'h3bf, 16'h0, 16'h0); tick();
    check("neg_below", {62'd0, data_out_valid}, 64'h0);
    // 0x8000 is most negative: not above high
    beat(0, 16'h8000, 16'h3c5, 16'h0, 16'h0); tick();
    check("neg_not_above", {60'd0, ts_valid, data_out_valid}, 64'h0);

    // Both channels trigger together
    beat(0, 16'h500, 16'h0, 16'h0, 16'h0);
    beat(1, 16'h1, 16'h0, 16'h0, 16'h0); tick();
    check("dual_valid", {60'd0, ts_valid, data_out_valid}, 64'hf);
    check("dual_ts0",   ts_out[63:0],   {50'd12, 14'd7});
    check("dual_ts1",   ts_out[127:64], {50'd0, 14'd0});

    // Gapped channel 1, continuous channel 0
    idle(1);
    beat(0, 16'h500, 16'h1, 16'h0, 16'h0); tick();
    check("gap1", {62'd0, data_out_valid}, 64'h1);
    beat(0, 16'h500, 16'h2, 16'h0, 16'h0); tick();
    check("gap2", {62'd0, data_out_valid}, 64'h1);
    beat(0, 16'h500, 16'h3, 16'h0, 16'h0);
    beat(1, 16'h0, 16'h0, 16'h0, 16'h0); tick();
    check("gap_resume", {60'd0, ts_valid, data_out_valid}, 64'h3);
    check("ch1_data",   data_out[127:64], 64'h0);
    beat(0, 16'h0, 16'h0, 16'h0, 16'h0);
    beat(1, 16'hffff, 16'hffff, 16'hffff, 16'hffff); tick();
    check("both_leave", {62'd0, data_out_valid}, 64'h0);
    idle(0);
    beat(1, 16'h2, 16'h0, 16'h0, 16'h0); tick();
    check("ch1_retrig_valid", {60'd0, ts_valid, data_out_valid}, 64'ha);
    check("ch1_retrig_ts",    ts_out[127:64], {50'd3, 14'd2});

    // reset_state coinciding with beats: both evaluated as low, index 0
    reset_state = 1'b1;
    beat(0, 16'h401, 16'h0, 16'h0, 16'h0);
    beat(1, 16'h5, 16'h0, 16'h0, 16'h0); tick();
    reset_state = 1'b0;
    check("rs_valid", {60'd0, ts_valid, data_out_valid}, 64'hf);
    check("rs_ts0",   ts_out[63:0],   {T0_RS, 14'd0});
    check("rs_ts1",   ts_out[127:64], {T1_RS, 14'd0});
    idle(1);
    beat(0, 16'h0, 16'h0, 16'h0, 16'h0); tick();
    check("rs_leave", {62'd0, data_out_valid}, 64'h0);
    beat(0, 16'h401, 16'h0, 16'h0, 16'h0); tick();
    check("rs_next_ts", ts_out[63:0], {T0_AFTER, 14'd1});

    // Quiet window: thresholds 0x3ff/0x400, samples 0..0xff, 400 beats
    idle(0);
    cfg_data  = {16'h0400, 16'h03ff, 16'h0400, 16'h03ff};
    cfg_valid = 1'b1; tick();
    cfg_valid = 1'b0;
    quiet_hits = 0;
    for (int k = 0; k < 400; k++) begin
      beat(0, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)),
              16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)));
      beat(1, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)),
              16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)));
      tick();
      if (data_out_valid != 2'b00 || ts_valid != 2'b00) quiet_hits++;
    end
    check("quiet_no_output", 64'(quiet_hits), 64'd0);
    beat(0, 16'h401, 16'h0, 16'h0, 16'h0);
    beat(1, 16'h0, 16'h0, 16'h401, 16'h0); tick();
    check("quiet_ts0", ts_out[63:0],   {T0_QUIET, 14'd2});
    check("quiet_ts1", ts_out[127:64], {T1_QUIET, 14'd1});

    // Reset mid-event: nothing emitted for the reset-cycle beat
    reset = 1'b1;
    beat(0, 16'h401, 16'h0, 16'h0, 16'h0); tick();
    reset = 1'b0;
    check("reset_mid_event", {60'd0, ts_valid, data_out_valid}, 64'h0);
    idle(1);
    beat(0, 16'h1, 16'h0, 16'h0, 16'h0); tick();
    check("post_reset_ts", ts_out[63:0], {50'd0, 14'd0});
    check("post_reset_valid", {60'd0, ts_valid, data_out_valid}, 64'h5);

    idle(0);
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axis_sample_discriminator.md
# axis_sample_discriminator

Per-channel hysteresis gate for the receive chain. It forwards only the parallel-sample beats that belong to an "active" event: the event starts when any sample exceeds the high threshold and ends when all samples fall below the low threshold. For every event start it emits a timestamp so that downstream buffering can reconstruct the timing of the sparse data stream.

## Interface
- SAMPLE_WIDTH, 16: bits per signed sample.
- PARALLEL_SAMPLES, 4: samples per beat. Sample j of a beat is bits [j*SAMPLE_WIDTH +: SAMPLE_WIDTH].
- N_CHANNELS, 2: number of independent channels.
- SAMPLE_INDEX_WIDTH, 14: width of the forwarded-beat counter.
- CLOCK_WIDTH, 50: width of the input-beat timer.
- clk  in  1: sole clock.
- reset  in  1: synchronous, active-high.
- data_in  Axis_Parallel_If slave  N_CHANNELS x SAMPLE_WIDTH*PARALLEL_SAMPLES: input beats. The valid bit is per channel. ready is held 1 for every channel.
- data_out  Axis_Parallel_If master  same width as data_in: gated beats. ready is ignored (no backpressure).
- timestamps_out  Axis_Parallel_If master  N_CHANNELS x (CLOCK_WIDTH+SAMPLE_INDEX_WIDTH): data is {timer, sample_index}. ready is ignored.
- config_in  Axis_Axis_If slave  N_CHANNELS*2*SAMPLE_WIDTH: threshold word. Channel i occupies bits [2*SAMPLE_WIDTH*i +: 2*SAMPLE_WIDTH] = {threshold_high[i], threshold_low[i]}. ready is held 1.
- reset_state  in  1: one-cycle pulse that clears is_high and sample_index on all channels.

## Operation
- Per channel, the block holds the following state:
  - threshold_high and threshold_low, SAMPLE_WIDTH each, signed.
  - is_high, 1 bit.
  - timer, CLOCK_WIDTH bits.
  - sample_index, SAMPLE_INDEX_WIDTH bits.
- On config_in.valid, all thresholds are latched. They apply to input beats from the next cycle onward.
- For each data_in beat accepted on channel i (data_in.valid[i]=1):
  - any_above: any sample > threshold_high. Comparison is signed and strict.
  - all_below: every sample < threshold_low. Comparison is signed and strict.
  - If any_above and is_high=0: emit a timestamp {timer, sample_index}, using the pre-increment values. Then set is_high=1.
  - If any_above and is_high=1: is_high stays 1; no timestamp.
  - Else if all_below: set is_high=0.
  - Otherwise (neither condition): is_high is unchanged.
  - If is_high is 1 after this update, forward the beat unchanged on data_out and increment sample_index.
  - timer increments on every accepted beat, whether or not it is forwarded.
- Both counters wrap modulo 2^width silently.
- A beat that enters the high state produces its timestamp and is itself forwarded.
- If reset_state coincides with a valid beat, the beat is evaluated with is_high=0 and sample_index=0.
- By default reset_state does not clear timer.
- Channels are fully independent; there is no cross-channel interaction.

## Timing
- data_out and timestamps_out are registered, with latency 1 cycle from the accepted input beat.
- The timestamp and the first forwarded beat of an event appear in the same cycle.
- Throughput is one beat per channel per cycle, continuous.
- Reset values:
  - data_out.valid=0 and timestamps_out.valid=0.
  - data registers 0.
  - thresholds 0, is_high 0, timer 0, sample_index 0.
- Reset mid-event drops the event. No timestamp or data is emitted for beats accepted in the reset cycle.
- A config write in the same cycle as a beat: that beat uses the old thresholds.

## Configuration
- SAMPLE_DISCRIMINATOR_RESET_TIMER_EN:
  - When defined, reset_state also clears timer to 0 on all channels.
  - When undefined (default), timer is cleared only by reset and runs monotonically across reset_state pulses.

## Test plan
- Thresholds 0/0, random samples 0..0x7fff, first beat all zeros:
  - The zero beat is dropped.
  - The next beat with any sample > 0 produces timestamp {1,0}.
  - Every following beat is forwarded, with sample_index counting up.
- Channel 0 at threshold_low=0x3c0, threshold_high=0x400, samples 0..0x4ff; channel 1 unchanged:
  - Channel 0 output equals the hysteresis model, with one timestamp per low-to-high entry.
  - Beats between the thresholds after a high beat are kept until a beat with all samples < 0x3c0 arrives.
- Both channels at low=0x3ff, high=0x400, samples 0..0xff, 400 beats: no data_out and no timestamps; timer advances by 400.
- reset_state pulse, then straddling data:
  - Timestamps restart with sample_index=0.
  - timer continues from its prior value, or 0 when SAMPLE_DISCRIMINATOR_RESET_TIMER_EN is defined.
- Gapped valid on one channel and continuous valid on the other:
  - timer counts only valid beats.
  - Channels produce independent streams.
- Beat with exactly one sample = threshold_high and the rest below: not a trigger (strict compare). A sample = threshold_high+1 triggers.
